// File: rtl/seq_voting.sv
// Sequential plurality vote counter: collects one vote per voter, then scans the
// candidate tallies one per cycle and reports the winner, its tally and a tie flag.
module seq_voting #(
    parameter int N = 2,
    parameter int M = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vote_valid,
    output logic         vote_ready,
    input  logic [N-1:0] vote,
    input  logic [M-1:0] voter_id,
    input  logic         close,
    input  logic         start,
    output logic         rejected,
    output logic         done,
    output logic [N-1:0] winner,
    output logic [M:0]   winner_count,
    output logic         tie
);

    localparam int           NUM_CAND = 2 ** N;
    localparam logic [N-1:0] LAST_IDX = N'(NUM_CAND - 1);

    typedef enum logic [1:0] {
        COLLECT,
        RESOLVE,
        DONE
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_idx;
    logic [M:0]     r_tally [NUM_CAND];
    logic [2**M-1:0] r_voted;
    logic           r_rejected;
    logic           r_done;
    logic [N-1:0]   r_winner;
    logic [M:0]     r_best;
    logic           r_tie;

    logic           w_ready;
    logic           w_accept;
    logic           w_dup;
    logic [M:0]     w_cur;

    assign w_ready  = (r_state == COLLECT);
    assign w_accept = vote_valid && w_ready && !r_voted[voter_id];
    assign w_dup    = vote_valid && w_ready &&  r_voted[voter_id];
    assign w_cur    = r_tally[r_idx];

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; mixing in blocking writes here would create ordering races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= COLLECT;
            r_idx      <= '0;
            // NOTE: the tally array is a handful of flops, not a RAM, so clearing
            // it in reset is legal and required for a clean election.
            for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= '0;
            r_voted    <= '0;
            r_rejected <= 1'b0;
            r_done     <= 1'b0;
            r_winner   <= '0;
            r_best     <= '0;
            r_tie      <= 1'b0;
        end else if (start) begin
            // Result outputs deliberately hold their last values across a restart.
            r_state    <= COLLECT;
            r_idx      <= '0;
            for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= '0;
            r_voted    <= '0;
            r_rejected <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rejected <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        r_tally[vote]     <= r_tally[vote] + (M+1)'(1);
                        r_voted[voter_id] <= 1'b1;
                    end
                    r_rejected <= w_dup;
                    if (close) begin
                        r_state <= RESOLVE;
                        r_idx   <= '0;
                    end
                end
                RESOLVE: begin
                    // Strictly-greater update keeps the lowest index on ties.
                    if (r_idx == '0) begin
                        r_best   <= w_cur;
                        r_winner <= '0;
                        r_tie    <= 1'b0;
                    end else if (w_cur > r_best) begin
                        r_best   <= w_cur;
                        r_winner <= r_idx;
                        r_tie    <= 1'b0;
                    end else if (w_cur == r_best) begin
                        r_tie    <= 1'b1;
                    end
                    if (r_idx == LAST_IDX) r_state <= DONE;
                    else                   r_idx   <= r_idx + N'(1);
                end
                DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

    assign vote_ready   = w_ready;
    assign rejected     = r_rejected;
    assign done         = r_done;
    assign winner       = r_winner;
    assign winner_count = r_best;
    assign tie          = r_tie;

endmodule

// File: tb/tb_seq_voting.sv
// Directed scoreboard bench for seq_voting: a reference model pushes the expected
// result when close is driven; it is popped and compared once done rises.
module tb_seq_voting;

    localparam int N        = 2;
    localparam int M        = 2;
    localparam int NUM_CAND = 2 ** N;
    localparam int NUM_VOTR = 2 ** M;
    localparam int LATENCY  = NUM_CAND + 1;

    typedef struct {
        logic [N-1:0] win;
        logic [M:0]   cnt;
        logic         tie;
    } result_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         vote_valid = 1'b0;
    logic         vote_ready;
    logic [N-1:0] vote = '0;
    logic [M-1:0] voter_id = '0;
    logic         close = 1'b0;
    logic         start = 1'b0;
    logic         rejected;
    logic         done;
    logic [N-1:0] winner;
    logic [M:0]   winner_count;
    logic         tie;

    int      n_cmp  = 0;
    int      n_fail = 0;
    int      m_tally [NUM_CAND];
    bit      m_voted [NUM_VOTR];
    result_t sb_q [$];

    seq_voting #(.N(N), .M(M)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vote_valid   (vote_valid),
        .vote_ready   (vote_ready),
        .vote         (vote),
        .voter_id     (voter_id),
        .close        (close),
        .start        (start),
        .rejected     (rejected),
        .done         (done),
        .winner       (winner),
        .winner_count (winner_count),
        .tie          (tie)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_CAND; i++) m_tally[i] = 0;
        for (int i = 0; i < NUM_VOTR; i++) m_voted[i] = 1'b0;
    endtask

    function automatic bit model_cast(input int id, input int cand);
        if (m_voted[id]) return 1'b1;
        m_voted[id] = 1'b1;
        m_tally[cand]++;
        return 1'b0;
    endfunction

    function automatic result_t model_result();
        result_t r;
        int best = -1;
        int win  = 0;
        int ties = 0;
        for (int i = 0; i < NUM_CAND; i++)
            if (m_tally[i] > best) begin
                best = m_tally[i];
                win  = i;
            end
        for (int i = 0; i < NUM_CAND; i++)
            if (m_tally[i] == best) ties++;
        r.win = N'(win);
        r.cnt = (M+1)'(best);
        r.tie = (ties > 1);
        return r;
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    // One vote per cycle; returns whether the model expects a rejection.
    task automatic cast(input int id, input int cand, output bit exp_rej);
        vote_valid = 1'b1;
        voter_id   = M'(id);
        vote       = N'(cand);
        exp_rej    = model_cast(id, cand);
        tick();
        vote_valid = 1'b0;
    endtask

    task automatic close_run(input string tag, input bit with_vote, input int id, input int cand);
        result_t exp_r;
        int      lat;
        bit      unused_rej;
        if (with_vote) begin
            vote_valid = 1'b1;
            voter_id   = M'(id);
            vote       = N'(cand);
            unused_rej = model_cast(id, cand);
        end
        sb_q.push_back(model_result());
        close = 1'b1;
        tick();
        close      = 1'b0;
        vote_valid = 1'b0;
        check({tag, "_ready_resolve"}, vote_ready, 1'b0);
        lat = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
        end
        check({tag, "_latency"}, lat, LATENCY);
        exp_r = sb_q.pop_front();
        check({tag, "_winner"}, winner, exp_r.win);
        check({tag, "_count"},  winner_count, exp_r.cnt);
        check({tag, "_tie"},    tie, exp_r.tie);
    endtask

    initial begin
        bit er;
        model_clear();

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_done", done, 1'b0);
        check("rst_rejected", rejected, 1'b0);
        check("rst_winner", winner, '0);
        check("rst_count", winner_count, '0);
        check("rst_tie", tie, 1'b0);
        rst_n = 1'b1;
        check("rst_ready", vote_ready, 1'b1);

        // Clear winner on (0,2),(1,2),(2,1),(3,3)
        cast(0, 2, er); check("s1_rej0", rejected, er);
        cast(1, 2, er);
        cast(2, 1, er);
        cast(3, 3, er); check("s1_rej3", rejected, er);
        close_run("s1", 1'b0, 0, 0);
        // Votes and close while in DONE are ignored
        vote_valid = 1'b1; voter_id = 2'd0; vote = 2'd0; close = 1'b1;
        tick();
        tick();
        vote_valid = 1'b0; close = 1'b0;
        check("s1_hold_done", done, 1'b1);
        check("s1_hold_winner", winner, 2'd2);
        check("s1_hold_count", winner_count, 3'd2);
        check("s1_hold_ready", vote_ready, 1'b0);

        // Tie between candidates 1 and 3
        do_start();
        check("s2_start_done", done, 1'b0);
        check("s2_start_ready", vote_ready, 1'b1);
        cast(0, 1, er);
        cast(1, 3, er);
        close_run("s2", 1'b0, 0, 0);

        // Duplicate voter is refused with a single-cycle pulse
        do_start();
        cast(0, 0, er); check("s3_rej_first", rejected, er);
        cast(0, 2, er); check("s3_rej_dup", rejected, er);
        tick();
        check("s3_rej_clear", rejected, 1'b0);
        close_run("s3", 1'b0, 0, 0);

        // No votes at all
        do_start();
        close_run("s4", 1'b0, 0, 0);

        // Vote arriving together with close
        do_start();
        close_run("s5", 1'b1, 2, 3);

        // Reset in the middle of RESOLVE aborts the election
        do_start();
        cast(0, 2, er);
        close = 1'b1;
        tick();
        close = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        check("s6_rst_done", done, 1'b0);
        check("s6_rst_winner", winner, '0);
        check("s6_rst_ready", vote_ready, 1'b1);
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();
        check("s6_no_result", done, 1'b0);
        for (int i = 0; i < NUM_VOTR; i++) cast(i, 1, er);
        close_run("s6", 1'b0, 0, 0);
        check("s6_exp_count4", winner_count, 3'd4);

        // start while in DONE clears done on the next edge
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s7_start_done", done, 1'b0);
        check("s7_start_ready", vote_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
